// File: rtl/alu_op_sequencer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_op_sequencer_pkg - opcodes, FSM states and widths for the sequencer  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package alu_op_sequencer_pkg;

  localparam int W_DEFAULT     = 4;
  localparam int CNT_W_DEFAULT = 8;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_NOT = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  localparam logic [2:0] OP_SLT = 3'd6;
  localparam logic [2:0] OP_EQ  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_HOLD    = 2'd3
  } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/alu_flag_tracker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_flag_tracker - sticky CF/OF accumulation and consumed-op counter     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module alu_flag_tracker #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             i_capture,
  input  logic             i_consume,
  input  logic             i_cf,
  input  logic             i_of,
  output logic             o_sticky_cf,
  output logic             o_sticky_of,
  output logic [CNT_W-1:0] o_op_count
);

  logic             r_sticky_cf;
  logic             r_sticky_of;
  logic [CNT_W-1:0] r_op_count;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_sticky_cf <= 1'b0;
      r_sticky_of <= 1'b0;
      r_op_count  <= '0;
    end else begin
      if (i_capture) begin
        r_sticky_cf <= r_sticky_cf | i_cf;
        r_sticky_of <= r_sticky_of | i_of;
      end
      // Counter wraps silently; no overflow indication is wanted.
      if (i_consume) begin
        r_op_count <= r_op_count + CNT_W'(1);
      end
    end
  end

  assign o_sticky_cf = r_sticky_cf;
  assign o_sticky_of = r_sticky_of;
  assign o_op_count  = r_op_count;

endmodule
`default_nettype wire

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_op_sequencer - registered valid/ready front-end for the 4-bit ALU    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter int W     = W_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_ctrl,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic             in_acc,
  output logic [2:0]       alu_ctrl,
  output logic [W-1:0]     alu_a,
  output logic [W-1:0]     alu_b,
  input  logic [W-1:0]     alu_y,
  input  logic             alu_cf,
  input  logic             alu_of,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_y,
  output logic             out_cf,
  output logic             out_of,
  output logic             sticky_cf,
  output logic             sticky_of,
  output logic [CNT_W-1:0] op_count
);

  seq_state_t   r_state;
  seq_state_t   w_next_state;
  logic         w_accept;
  logic         w_capture;
  logic         w_consume;

  logic [2:0]   r_alu_ctrl;
  logic [W-1:0] r_alu_a;
  logic [W-1:0] r_alu_b;
  logic [W-1:0] r_acc;
  logic [W-1:0] r_out_y;
  logic         r_out_cf;
  logic         r_out_of;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_capture    = 1'b0;
    w_consume    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          w_accept     = 1'b1;
          w_next_state = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_next_state = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        w_capture    = 1'b1;
        w_next_state = ST_HOLD;
      end
      ST_HOLD: begin
        if (out_ready) begin
          w_consume    = 1'b1;
          w_next_state = ST_IDLE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // ALU operands stay put between accepts; results stay put between captures.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_alu_ctrl <= 3'd0;
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_acc      <= '0;
      r_out_y    <= '0;
      r_out_cf   <= 1'b0;
      r_out_of   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_alu_ctrl <= in_ctrl;
        r_alu_a    <= in_acc ? r_acc : in_a;
        r_alu_b    <= in_b;
      end
      if (w_capture) begin
        r_out_y  <= alu_y;
        r_out_cf <= alu_cf;
        r_out_of <= alu_of;
        r_acc    <= alu_y;
      end
    end
  end

  alu_flag_tracker #(
    .CNT_W (CNT_W)
  ) u_flag_tracker (
    .clk         (clk),
    .clrn        (clrn),
    .i_capture   (w_capture),
    .i_consume   (w_consume),
    .i_cf        (alu_cf),
    .i_of        (alu_of),
    .o_sticky_cf (sticky_cf),
    .o_sticky_of (sticky_of),
    .o_op_count  (op_count)
  );

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_HOLD);
  assign alu_ctrl  = r_alu_ctrl;
  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign out_y     = r_out_y;
  assign out_cf    = r_out_cf;
  assign out_of    = r_out_of;

endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_alu_op_sequencer - directed bench with a behavioural 4-bit ALU        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_alu_op_sequencer;
  import alu_op_sequencer_pkg::*;

  logic       clk = 1'b0;
  logic       clrn;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_ctrl;
  logic [3:0] in_a;
  logic [3:0] in_b;
  logic       in_acc;
  logic [2:0] alu_ctrl;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [3:0] alu_y;
  logic       alu_cf;
  logic       alu_of;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_y;
  logic       out_cf;
  logic       out_of;
  logic       sticky_cf;
  logic       sticky_of;
  logic [7:0] op_count;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(
    .W     (4),
    .CNT_W (8)
  ) dut (
    .clk       (clk),
    .clrn      (clrn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_acc    (in_acc),
    .alu_ctrl  (alu_ctrl),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_y     (alu_y),
    .alu_cf    (alu_cf),
    .alu_of    (alu_of),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_cf    (out_cf),
    .out_of    (out_of),
    .sticky_cf (sticky_cf),
    .sticky_of (sticky_of),
    .op_count  (op_count)
  );

  // Combinational ALU: SUB carry is the carry-out of A + ~B + 1.
  logic [4:0] w_sum;
  always_comb begin
    w_sum  = 5'd0;
    alu_y  = 4'd0;
    alu_cf = 1'b0;
    alu_of = 1'b0;
    case (alu_ctrl)
      OP_ADD: begin
        w_sum  = {1'b0, alu_a} + {1'b0, alu_b};
        alu_y  = w_sum[3:0];
        alu_cf = w_sum[4];
        alu_of = (alu_a[3] == alu_b[3]) && (alu_y[3] != alu_a[3]);
      end
      OP_SUB: begin
        w_sum  = {1'b0, alu_a} + {1'b0, ~alu_b} + 5'd1;
        alu_y  = w_sum[3:0];
        alu_cf = w_sum[4];
        alu_of = (alu_a[3] != alu_b[3]) && (alu_y[3] != alu_a[3]);
      end
      OP_NOT: alu_y = ~alu_a;
      OP_AND: alu_y = alu_a & alu_b;
      OP_OR:  alu_y = alu_a | alu_b;
      OP_XOR: alu_y = alu_a ^ alu_b;
      OP_SLT: alu_y = ($signed(alu_a) < $signed(alu_b)) ? 4'd1 : 4'd0;
      OP_EQ:  alu_y = (alu_a == alu_b) ? 4'd1 : 4'd0;
      default: alu_y = 4'd0;
    endcase
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic send(input logic [2:0] c, input logic [3:0] a, input logic [3:0] b,
                      input logic acc);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_ctrl  = c;
    in_a     = a;
    in_b     = b;
    in_acc   = acc;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("accept_bound", 16'(n < 20), 16'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_hold();
    int n;
    n = 0;
    while (!out_valid && n < 8) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("hold_bound", 16'(out_valid), 16'd1);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clrn      = 1'b0;
    in_valid  = 1'b0;
    in_ctrl   = 3'd0;
    in_a      = 4'd0;
    in_b      = 4'd0;
    in_acc    = 1'b0;
    out_ready = 1'b0;

    #2;
    check("rst_out_valid", 16'(out_valid), 16'd0);
    check("rst_op_count",  16'(op_count),  16'd0);
    check("rst_out_y",     16'(out_y),     16'd0);
    @(negedge clk);
    clrn = 1'b1;
    #1;
    check("rst_in_ready",  16'(in_ready),  16'd1);

    // ADD 7+1: signed overflow into 8
    send(OP_ADD, 4'd7, 4'd1, 1'b0);
    wait_hold();
    check("add_y",         16'(out_y),     16'h8);
    check("add_cf",        16'(out_cf),    16'd0);
    check("add_of",        16'(out_of),    16'd1);
    check("add_sticky_of", 16'(sticky_of), 16'd1);
    check("add_sticky_cf", 16'(sticky_cf), 16'd0);
    consume();
    check("add_count",     16'(op_count),  16'd1);
    check("add_in_ready",  16'(in_ready),  16'd1);
    check("add_y_held",    16'(out_y),     16'h8);

    // SUB 3-5 with exact latency: HOLD on the third edge counting the accept edge
    send(OP_SUB, 4'd3, 4'd5, 1'b0);
    check("sub_lat0",      16'(out_valid), 16'd0);
    check("sub_alu_ctrl",  16'(alu_ctrl),  16'(OP_SUB));
    check("sub_alu_b",     16'(alu_b),     16'h5);
    @(posedge clk);
    #1;
    check("sub_lat1",      16'(out_valid), 16'd0);
    @(posedge clk);
    #1;
    check("sub_lat2",      16'(out_valid), 16'd1);
    check("sub_y",         16'(out_y),     16'hE);
    check("sub_cf",        16'(out_cf),    16'd0);
    check("sub_of",        16'(out_of),    16'd0);
    consume();
    check("sub_count",     16'(op_count),  16'd2);

    // Accumulate: 5+5=10, then A:=10 (in_a=9 ignored) + 6 = 0 with carry
    send(OP_ADD, 4'd5, 4'd5, 1'b0);
    wait_hold();
    check("acc1_y",        16'(out_y),     16'hA);
    check("acc1_of",       16'(out_of),    16'd1);
    consume();
    send(OP_ADD, 4'd9, 4'd6, 1'b1);
    check("acc2_alu_a",    16'(alu_a),     16'hA);
    wait_hold();
    check("acc2_y",        16'(out_y),     16'h0);
    check("acc2_cf",       16'(out_cf),    16'd1);
    check("acc2_of",       16'(out_of),    16'd0);
    check("acc2_sticky_cf",16'(sticky_cf), 16'd1);

    // Backpressure with a competing request that must not be accepted
    in_valid = 1'b1;
    in_ctrl  = OP_AND;
    in_a     = 4'hF;
    in_b     = 4'hF;
    in_acc   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("bp_out_valid", 16'(out_valid), 16'd1);
      check("bp_out_y",     16'(out_y),     16'h0);
      check("bp_in_ready",  16'(in_ready),  16'd0);
      check("bp_count",     16'(op_count),  16'd3);
      check("bp_alu_ctrl",  16'(alu_ctrl),  16'(OP_ADD));
    end
    in_valid = 1'b0;
    consume();
    check("bp_count_after", 16'(op_count), 16'd4);
    check("bp_alu_a_held",  16'(alu_a),    16'hA);

    // Reset while the op sits in ISSUE
    send(OP_XOR, 4'd5, 4'd3, 1'b0);
    clrn = 1'b0;
    #1;
    check("mid_alu_ctrl",  16'(alu_ctrl),  16'd0);
    check("mid_alu_a",     16'(alu_a),     16'd0);
    check("mid_alu_b",     16'(alu_b),     16'd0);
    check("mid_out_y",     16'(out_y),     16'd0);
    check("mid_out_cf",    16'(out_cf),    16'd0);
    check("mid_sticky_cf", 16'(sticky_cf), 16'd0);
    check("mid_sticky_of", 16'(sticky_of), 16'd0);
    check("mid_count",     16'(op_count),  16'd0);
    check("mid_out_valid", 16'(out_valid), 16'd0);
    @(posedge clk);
    @(negedge clk);
    clrn = 1'b1;
    @(posedge clk);
    #1;
    check("mid_in_ready",  16'(in_ready),  16'd1);
    check("mid_no_valid",  16'(out_valid), 16'd0);

    // Accumulate right after reset uses acc=0
    send(OP_ADD, 4'd7, 4'd3, 1'b1);
    check("acc0_alu_a",    16'(alu_a),     16'h0);
    wait_hold();
    check("acc0_y",        16'(out_y),     16'h3);
    consume();

    // Counter wrap: 256 consumed ops since reset
    for (int i = 1; i < 255; i++) begin
      send(OP_OR, 4'd1, 4'd2, 1'b0);
      wait_hold();
      consume();
    end
    check("wrap_255",      16'(op_count),  16'd255);
    send(OP_OR, 4'd1, 4'd2, 1'b0);
    wait_hold();
    check("or_y",          16'(out_y),     16'h3);
    consume();
    check("wrap_0",        16'(op_count),  16'd0);

    // Signed compare and equality
    send(OP_SLT, 4'b1000, 4'd1, 1'b0);
    wait_hold();
    check("slt_y",         16'(out_y),     16'h1);
    consume();
    send(OP_EQ, 4'd9, 4'd9, 1'b0);
    wait_hold();
    check("eq_y",          16'(out_y),     16'h1);
    consume();
    check("final_count",   16'(op_count),  16'd2);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
